// File: rtl/dmem_responder.sv
// Multi-cycle data-memory responder for the load/store port.
// Ports: clk_i/rst_i, req_i/we_i/addr_i/wdata_i in; rdata_o/ack_o/err_o/stall_o out.
module dmem_responder #(
  parameter int DEPTH_WORDS = 256,
  parameter int LATENCY     = 4
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        req_i,
  input  logic        we_i,
  input  logic [31:0] addr_i,
  input  logic [31:0] wdata_i,
  output logic [31:0] rdata_o,
  output logic        ack_o,
  output logic        err_o,
  output logic        stall_o
);

  localparam int          AW    = $clog2(DEPTH_WORDS);
  localparam logic [31:0] LIMIT = 32'(4 * DEPTH_WORDS);
  localparam logic [31:0] CNT0  = 32'(LATENCY - 1);

  typedef enum logic [1:0] {
    IDLE,
    BUSY,
    RESP
  } state_t;

  state_t      state;
  logic [31:0] cnt;
  logic        we_q;
  logic [AW-1:0] idx_q;
  logic [31:0] wdata_q;

  logic [31:0] mem [DEPTH_WORDS];

  logic bad;
  logic wr_en;

  assign bad = (addr_i[1:0] != 2'b00)
             || (addr_i >= LIMIT);

  // reset forces IDLE, so an aborted store never reaches the array
  assign wr_en = (state == BUSY)
               && (cnt == '0) && we_q;

  assign stall_o = req_i & ~ack_o;

  always_ff @(posedge clk_i) begin
    if (wr_en) mem[idx_q] <= wdata_q;
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state   <= IDLE;
      cnt     <= '0;
      we_q    <= 1'b0;
      idx_q   <= '0;
      wdata_q <= '0;
      ack_o   <= 1'b0;
      err_o   <= 1'b0;
      rdata_o <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          ack_o <= 1'b0;
          err_o <= 1'b0;
          if (req_i) begin
            we_q    <= we_i;
            idx_q   <= addr_i[2 +: AW];
            wdata_q <= wdata_i;
            if (bad) begin
              state <= RESP;
              ack_o <= 1'b1;
              err_o <= 1'b1;
            end else begin
              state <= BUSY;
              cnt   <= CNT0;
            end
          end
        end
        BUSY: begin
          if (cnt != '0) begin
            cnt <= cnt - 32'd1;
          end else begin
            if (!we_q) rdata_o <= mem[idx_q];
            state <= RESP;
            ack_o <= 1'b1;
            err_o <= 1'b0;
          end
        end
        RESP: begin
          state <= IDLE;
          ack_o <= 1'b0;
          err_o <= 1'b0;
        end
        default: begin
          state <= IDLE;
          ack_o <= 1'b0;
          err_o <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: doc/dmem_responder.md
# dmem_responder

Multi-cycle data-memory responder serving the CPU's load/store port. Accepts one word-aligned read or write request at a time through a request/acknowledge handshake and models a fixed access latency. Drives a stall back to the pipeline while a request is outstanding. Flags misaligned and out-of-range addresses instead of accessing storage.

## Interface
Parameters:
- DEPTH_WORDS, 256, number of 32-bit words stored; power of two.
- LATENCY, 4, cycles spent in BUSY before the array access; must be ≥1.

Ports:
- clk_i  in  1  single clock; all state updates on the rising edge.
- rst_i  in  1  reset, asynchronous and active-low.
- req_i  in  1  request valid; held with all fields stable until ack_o.
- we_i  in  1  1 = write (store), 0 = read (load).
- addr_i  in  32  byte address.
- wdata_i  in  32  store data.
- rdata_o  out  32  load data; registered; holds the last successful read.
- ack_o  out  1  one-cycle completion pulse.
- err_o  out  1  valid with ack_o; 1 = request rejected.
- stall_o  out  1  combinational: req_i & ~ack_o.

## Operation
- Storage: DEPTH_WORDS x 32 array, indexed by addr_i[2 +: log2(DEPTH_WORDS)]. The array is not cleared by reset.
- FSM states: IDLE, BUSY, RESP. A 32-bit counter cnt tracks BUSY time.
- IDLE, req_i=0: remain in IDLE.
- IDLE, req_i=1: capture we_i, addr_i, wdata_i into internal registers.
  - If addr_i[1:0]≠0 or addr_i ≥ 4*DEPTH_WORDS: set the error flag and go to RESP. No array access.
  - Otherwise clear the error flag, load cnt=LATENCY-1 and go to BUSY.
- BUSY, cnt≠0: decrement cnt.
- BUSY, cnt=0: perform the access using the captured fields, then go to RESP.
  - Write: array[index] ← wdata.
  - Read: rdata_o ← array[index].
- RESP: ack_o=1, and err_o equals the error flag. Next state is always IDLE.
- Inputs are ignored outside IDLE. A request that is still asserted in the cycle after RESP is treated as a new transaction.
- If req_i is deasserted mid-BUSY, that is a protocol violation. The transaction still completes and acknowledges.
- rdata_o changes only on a successful read. Writes and errors leave it unchanged.
- err_o is 0 whenever ack_o is 0.

## Timing
- Reset (rst_i=0, asynchronous):
  - state is IDLE; cnt=0; ack_o=0; err_o=0; rdata_o=0.
  - stall_o then follows req_i.
- Reset asserted mid-BUSY aborts the transaction: no write occurs and no ack is issued.
- Cycle numbering: cycle 0 is the first cycle req_i=1 is sampled in IDLE.
  - Valid request: BUSY during cycles 1..LATENCY; access at the end of cycle LATENCY; ack_o=1 in cycle LATENCY+1. Read data is valid on rdata_o in that same cycle.
  - Error request: ack_o=1, err_o=1 in cycle 1.
- stall_o is high in cycles 0..LATENCY and low in the ack cycle, so the pipeline advances on the ack edge.
- Back-to-back requests have one IDLE turnaround cycle. The next request's cycle 0 is the cycle after RESP, giving a throughput of one access per LATENCY+2 cycles.
- LATENCY=1: BUSY lasts exactly one cycle and ack arrives in cycle 2.

## Test plan
- Reset: hold rst_i=0 with req_i=1 → ack_o=0, err_o=0, rdata_o=0x00000000, stall_o=1. Release with req_i=0 → stall_o=0.
- Write then read (LATENCY=4):
  - Store 0xDEADBEEF to 0x10 → ack in cycle 5 with err_o=0; stall_o high in cycles 0–4.
  - Load from 0x10 → rdata_o=0xDEADBEEF in its ack cycle; the previous rdata_o is unchanged until then.
- Misaligned: store to 0x13 → ack_o=1, err_o=1 in cycle 1. A subsequent load of 0x10 still returns 0xDEADBEEF.
- Out of range (DEPTH_WORDS=256): load from 0x400 → err_o=1 in cycle 1 and rdata_o unchanged. Load from 0x3FC → err_o=0.
- Reset mid-operation: store 0x12345678 to 0x20 and pull rst_i low in cycle 2 → no ack. After release, load of 0x20 returns the prior contents.
- Back-to-back with req_i held high: a store then a load to 0x40 → acks in cycles 5 and 11. The load returns the stored value, and stall_o is low only in cycles 5 and 11.
